bip_control_unit: RTL and testbench

- Sequencing control unit for the BIP core; sits directly downstream of the program memory and drives the program counter.
- Consumes the 16-bit instruction addressed by the PC and decodes it into datapath strobes.
- Paces the PC with `pc_inc`, or with `WrPC` plus `address_bus` for jumps.
- Fixed fetch/execute FSM: two cycles per instruction, three for JMP.

---
 rtl/bip_pkg.sv | 48 ++++
 rtl/bip_decoder.sv | 53 +++++
 rtl/bip_control_unit.sv | 124 ++++++++++++
 tb/tb_bip_control_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: widths, opcodes, FSM state
// encoding, accumulator mux codes and the decoded strobe bundle.
package bip_pkg;

    localparam int unsigned AB_DEF   = 11;
    localparam int unsigned OPW_DEF  = 5;
    localparam int unsigned IW_DEF   = OPW_DEF + AB_DEF;
    localparam int unsigned CNTW_DEF = 32;

    localparam logic [OPW_DEF-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPW_DEF-1:0] OP_STO  = 5'b00001;
    localparam logic [OPW_DEF-1:0] OP_LD   = 5'b00010;
    localparam logic [OPW_DEF-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPW_DEF-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPW_DEF-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPW_DEF-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPW_DEF-1:0] OP_SUBI = 5'b00111;
    localparam logic [OPW_DEF-1:0] OP_JMP  = 5'b01000;

    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StJmp2,
        StHalt
    } state_t;

    // Per-opcode control bundle; halt/jmp steer the FSM, the rest are strobes.
    typedef struct packed {
        logic       pc_inc;
        logic       wr_pc;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       halt;
        logic       jmp;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: maps an opcode onto the control bundle.
// The caller gates the result with the EXEC state.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPW_DEF-1:0] opcode,
    output ctrl_t              ctrl
);

    // Decode table; unlisted opcodes behave as NOP (pc_inc only).
    always_comb begin
        ctrl        = CTRL_IDLE;
        ctrl.pc_inc = 1'b1;
        case (opcode)
            OP_HLT: begin
                ctrl.pc_inc = 1'b0;
                ctrl.halt   = 1'b1;
            end
            OP_STO: begin
                ctrl.wr_ram = 1'b1;
            end
            OP_LD: begin
                ctrl.rd_ram = 1'b1;
                ctrl.sel_a  = SEL_A_RAM;
                ctrl.wr_acc = 1'b1;
            end
            OP_LDI: begin
                ctrl.sel_a  = SEL_A_IMM;
                ctrl.wr_acc = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                ctrl.rd_ram = 1'b1;
                ctrl.sel_b  = 1'b0;
                ctrl.op     = (opcode == OP_SUB);
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.wr_acc = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                ctrl.sel_b  = 1'b1;
                ctrl.op     = (opcode == OP_SUBI);
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.wr_acc = 1'b1;
            end
            OP_JMP: begin
                ctrl.pc_inc = 1'b0;
                ctrl.wr_pc  = 1'b1;
                ctrl.jmp    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: fetch/execute FSM (2 cycles per instruction, 3 for JMP)
// driving PC pacing and datapath strobes.
// Optional macro CU_CYCLE_CNT_EN adds the cycle_count output.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int unsigned AB   = AB_DEF,
    parameter int unsigned OPW  = OPW_DEF,
    parameter int unsigned IW   = OPW + AB,
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_bip,
    input  logic [IW-1:0]   instr,
    output logic            pc_inc,
    output logic            WrPC,
    output logic [AB-1:0]   address_bus,
    output logic [AB-1:0]   operand,
    output logic [1:0]      SelA,
    output logic            SelB,
    output logic            Op,
    output logic            WrAcc,
    output logic            WrRam,
    output logic            RdRam,
`ifdef CU_CYCLE_CNT_EN
    output logic [CNTW-1:0] cycle_count,
`endif
    output logic            halted
);

    state_t             state_q, state_d;
    logic [OPW_DEF-1:0] opcode_q;
    logic [AB-1:0]      operand_q;
    logic [AB-1:0]      addr_q;
    ctrl_t              dec;
    ctrl_t              ctrl;

    bip_decoder u_decoder (
        .opcode (opcode_q),
        .ctrl   (dec)
    );

    // State register plus IR/operand capture and jump-target hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            opcode_q  <= '0;
            operand_q <= '0;
            addr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StFetch) begin
                opcode_q  <= instr[IW-1:AB];
                operand_q <= instr[AB-1:0];
            end
            if (state_q == StExec && dec.jmp) begin
                addr_q <= operand_q;
            end
        end
    end

    // Next-state logic and strobe gating; strobes only leave EXEC/JMP2.
    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_IDLE;
        unique case (state_q)
            StIdle: begin
                if (start_bip) state_d = StFetch;
            end
            StFetch: begin
                state_d = StExec;
            end
            StExec: begin
                ctrl = dec;
                if (dec.halt)     state_d = StHalt;
                else if (dec.jmp) state_d = StJmp2;
                else              state_d = StFetch;
            end
            StJmp2: begin
                // Second WrPC pulse: PC loads on alternate WrPC cycles.
                ctrl.wr_pc = 1'b1;
                state_d    = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output mapping; the jump target is forwarded in EXEC, then held.
    always_comb begin
        pc_inc      = ctrl.pc_inc;
        WrPC        = ctrl.wr_pc;
        SelA        = ctrl.sel_a;
        SelB        = ctrl.sel_b;
        Op          = ctrl.op;
        WrAcc       = ctrl.wr_acc;
        WrRam       = ctrl.wr_ram;
        RdRam       = ctrl.rd_ram;
        operand     = operand_q;
        address_bus = (state_q == StExec && dec.jmp) ? operand_q : addr_q;
        halted      = (state_q == StHalt);
    end

`ifdef CU_CYCLE_CNT_EN
    logic [CNTW-1:0] cnt_q;

    // Active-cycle counter; frozen in IDLE and HALT, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q != StIdle && state_q != StHalt) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed self-checking bench for bip_control_unit.
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_bip;
    logic [15:0] instr;
    logic        pc_inc, WrPC, SelB, Op, WrAcc, WrRam, RdRam, halted;
    logic [10:0] address_bus, operand;
    logic [1:0]  SelA;
`ifdef CU_CYCLE_CNT_EN
    logic [31:0] cycle_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bip_control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start_bip   (start_bip),
        .instr       (instr),
        .pc_inc      (pc_inc),
        .WrPC        (WrPC),
        .address_bus (address_bus),
        .operand     (operand),
        .SelA        (SelA),
        .SelB        (SelB),
        .Op          (Op),
        .WrAcc       (WrAcc),
        .WrRam       (WrRam),
        .RdRam       (RdRam),
`ifdef CU_CYCLE_CNT_EN
        .cycle_count (cycle_count),
`endif
        .halted      (halted)
    );

    // Strobe vector layout: {pc_inc, WrPC, SelA[1:0], SelB, Op, WrAcc, WrRam, RdRam}
    localparam logic [8:0] S_NONE = 9'b0_0_00_0_0_0_0_0;
    localparam logic [8:0] S_LDI  = 9'b1_0_01_0_0_1_0_0;
    localparam logic [8:0] S_LD   = 9'b1_0_00_0_0_1_0_1;
    localparam logic [8:0] S_ADDI = 9'b1_0_10_1_0_1_0_0;
    localparam logic [8:0] S_SUB  = 9'b1_0_10_0_1_1_0_1;
    localparam logic [8:0] S_STO  = 9'b1_0_00_0_0_0_1_0;
    localparam logic [8:0] S_NOP  = 9'b1_0_00_0_0_0_0_0;
    localparam logic [8:0] S_JMP  = 9'b0_1_00_0_0_0_0_0;

    function automatic logic [8:0] strobes();
        return {pc_inc, WrPC, SelA, SelB, Op, WrAcc, WrRam, RdRam};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in FETCH: present word, check EXEC, then check the following FETCH.
    task automatic run_instr(input string tag, input logic [15:0] word, input logic [8:0] exp);
        instr = word;
        tick();
        check({tag, " exec strobes"}, {23'd0, strobes()}, {23'd0, exp});
        check({tag, " operand"}, {21'd0, operand}, {21'd0, word[10:0]});
        tick();
        check({tag, " next fetch quiet"}, {23'd0, strobes()}, {23'd0, S_NONE});
    endtask

    initial begin
        reset     = 1'b1;
        start_bip = 1'b0;
        instr     = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        // Idle with start low: nothing moves.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle strobes", {23'd0, strobes()}, {23'd0, S_NONE});
            check("idle halted", {31'd0, halted}, 32'd0);
        end
        check("idle address_bus", {21'd0, address_bus}, 32'd0);
        check("idle operand", {21'd0, operand}, 32'd0);

        // Start: first cycle is FETCH with no strobes.
        start_bip = 1'b1;
        instr     = 16'h1807;  // LDI 7
        tick();
        check("first fetch quiet", {23'd0, strobes()}, {23'd0, S_NONE});
        run_instr("LDI 7", 16'h1807, S_LDI);

        run_instr("LD 3", 16'h1003, S_LD);
        run_instr("ADDI 2", 16'h2802, S_ADDI);
        run_instr("SUB 4", 16'h3004, S_SUB);
        run_instr("STO 5", 16'h0805, S_STO);

        // JMP 0x20: WrPC for two cycles, target held afterwards.
        instr = 16'h4020;
        tick();
        check("jmp exec strobes", {23'd0, strobes()}, {23'd0, S_JMP});
        check("jmp exec address", {21'd0, address_bus}, 32'h20);
        tick();
        check("jmp2 strobes", {23'd0, strobes()}, {23'd0, S_JMP});
        check("jmp2 address", {21'd0, address_bus}, 32'h20);
        tick();
        check("post-jmp fetch", {23'd0, strobes()}, {23'd0, S_NONE});
        check("post-jmp address held", {21'd0, address_bus}, 32'h20);

        // Undefined opcode behaves as NOP.
        run_instr("NOP 0xFFFF", 16'hFFFF, S_NOP);
        check("address held after nop", {21'd0, address_bus}, 32'h20);

        // HLT: no strobes in EXEC, then halted forever.
        instr = 16'h0000;
        tick();
        check("hlt exec strobes", {23'd0, strobes()}, {23'd0, S_NONE});
        check("hlt exec halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            start_bip = ~start_bip;
            tick();
            check("halt halted", {31'd0, halted}, 32'd1);
            check("halt strobes", {23'd0, strobes()}, {23'd0, S_NONE});
        end
`ifdef CU_CYCLE_CNT_EN
        // Active cycles: LDI,LD,ADDI,SUB,STO (10) + JMP (3) + NOP (2) + HLT (2).
        check("cycle_count at halt", cycle_count, 32'd17);
        tick();
        check("cycle_count frozen", cycle_count, 32'd17);
`endif

        // Reset while in JMP2 abandons the jump.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        start_bip = 1'b1;
        instr     = 16'h4123;
        tick();  // FETCH
        tick();  // EXEC
        tick();  // JMP2
        check("jmp2 before reset WrPC", {31'd0, WrPC}, 32'd1);
        check("jmp2 before reset address", {21'd0, address_bus}, 32'h123);
        reset = 1'b1;
        tick();
        check("reset in jmp2 strobes", {23'd0, strobes()}, {23'd0, S_NONE});
        check("reset in jmp2 address", {21'd0, address_bus}, 32'd0);
        check("reset in jmp2 operand", {21'd0, operand}, 32'd0);
        check("reset in jmp2 halted", {31'd0, halted}, 32'd0);
        reset     = 1'b0;
        start_bip = 1'b0;
        tick();
        check("idle after reset", {23'd0, strobes()}, {23'd0, S_NONE});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
